// File: rtl/gcd_seq.sv
// Multi-cycle GCD engine: one subtract step per clock between a valid/ready
// operand handshake and a valid/ready result handshake with step count.
module gcd_seq #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned CNT_W = WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] gcd_out,
  output logic [CNT_W-1:0] iter_out
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   a_q, a_d;
  logic [WIDTH-1:0]   b_q, b_d;
  logic [CNT_W-1:0]   iter_q, iter_d;
  logic               in_ready_q, in_ready_d;
  logic               out_valid_q, out_valid_d;
  logic [WIDTH-1:0]   gcd_q, gcd_d;
  logic [CNT_W-1:0]   iter_out_q, iter_out_d;

  // Next-state and registered-output logic
  always_comb begin
    state_d     = state_q;
    a_d         = a_q;
    b_d         = b_q;
    iter_d      = iter_q;
    in_ready_d  = in_ready_q;
    out_valid_d = out_valid_q;
    gcd_d       = gcd_q;
    iter_out_d  = iter_out_q;

    case (state_q)
      IDLE: begin
        // in_ready is low for the first IDLE cycle after a result leaves
        in_ready_d = 1'b1;
        if (in_valid && in_ready_q) begin
          a_d        = a_in;
          b_d        = b_in;
          iter_d     = '0;
          in_ready_d = 1'b0;
          state_d    = CALC;
        end
      end
      CALC: begin
        if (a_q == '0) begin
          gcd_d       = b_q;
          iter_out_d  = iter_q;
          out_valid_d = 1'b1;
          state_d     = DONE;
        end else if (b_q == '0 || a_q == b_q) begin
          gcd_d       = a_q;
          iter_out_d  = iter_q;
          out_valid_d = 1'b1;
          state_d     = DONE;
        end else if (a_q > b_q) begin
          a_d    = a_q - b_q;
          iter_d = iter_q + CNT_W'(1);
        end else begin
          b_d    = b_q - a_q;
          iter_d = iter_q + CNT_W'(1);
        end
      end
      DONE: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      a_q         <= '0;
      b_q         <= '0;
      iter_q      <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      gcd_q       <= '0;
      iter_out_q  <= '0;
    end else begin
      state_q     <= state_d;
      a_q         <= a_d;
      b_q         <= b_d;
      iter_q      <= iter_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      gcd_q       <= gcd_d;
      iter_out_q  <= iter_out_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign gcd_out   = gcd_q;
  assign iter_out  = iter_out_q;

endmodule

// File: tb/tb_gcd_seq.sv
// Directed and random bench for gcd_seq; expected results are queued when
// operands are driven and compared when the engine presents its result.
module tb_gcd_seq;

  localparam int unsigned WIDTH = 8;
  localparam int unsigned CNT_W = WIDTH;

  logic             clk;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a_in;
  logic [WIDTH-1:0] b_in;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] gcd_out;
  logic [CNT_W-1:0] iter_out;

  typedef struct packed {
    logic [WIDTH-1:0] g;
    logic [CNT_W-1:0] it;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  gcd_seq #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a_in      (a_in),
    .b_in      (b_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .gcd_out   (gcd_out),
    .iter_out  (iter_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Euclid by division; subtraction count is the quotient sum minus the final equal step
  function automatic void model(input int unsigned a, input int unsigned b,
                                output int unsigned g, output int unsigned it);
    int unsigned x, y, r, sum;
    if (a == 0 || b == 0) begin
      g  = a | b;
      it = 0;
    end else begin
      x   = (a > b) ? a : b;
      y   = (a > b) ? b : a;
      sum = 0;
      while (y != 0) begin
        sum += x / y;
        r = x % y;
        x = y;
        y = r;
      end
      g  = x;
      it = sum - 1;
    end
  endfunction

  task automatic do_op(input int unsigned a, input int unsigned b,
                       input int unsigned pre_gap, input int unsigned hold,
                       input bit inject);
    int unsigned g, it, cyc;
    exp_t        e, got;
    bit          lowok, stable;
    model(a, b, g, it);
    e.g  = WIDTH'(g);
    e.it = CNT_W'(it);
    sb.push_back(e);
    out_ready = (hold == 0);
    repeat (pre_gap) @(negedge clk);
    cyc = 0;
    while (!in_ready && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    chk("in_ready_before_accept", 32'(in_ready), 32'd1);
    in_valid = 1'b1;
    a_in     = WIDTH'(a);
    b_in     = WIDTH'(b);
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    a_in     = WIDTH'($urandom);
    b_in     = WIDTH'($urandom);
    cyc   = 0;
    lowok = !in_ready;
    while (!out_valid && cyc < 300) begin
      @(negedge clk);
      cyc++;
      if (in_ready) lowok = 1'b0;
    end
    chk("latency", cyc, it + 1);
    chk("in_ready_low_during_calc", 32'(lowok), 32'd1);
    got.g  = gcd_out;
    got.it = iter_out;
    stable = 1'b1;
    repeat (hold) begin
      @(negedge clk);
      if (gcd_out !== got.g || iter_out !== got.it || !out_valid || in_ready)
        stable = 1'b0;
      if (inject) begin
        in_valid = 1'b1;
        a_in     = WIDTH'($urandom);
        b_in     = WIDTH'($urandom);
      end
    end
    if (hold > 0) chk("held_stable", 32'(stable), 32'd1);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("out_valid_drop", 32'(out_valid), 32'd0);
    chk("in_ready_still_low", 32'(in_ready), 32'd0);
    @(negedge clk);
    chk("in_ready_return", 32'(in_ready), 32'd1);
    chk("no_spurious_valid", 32'(out_valid), 32'd0);
    if (sb.size() == 0) begin
      chk("scoreboard_nonempty", 32'd0, 32'd1);
    end else begin
      e = sb.pop_front();
      chk("gcd_out", 32'(got.g), 32'(e.g));
      chk("iter_out", 32'(got.it), 32'(e.it));
    end
  endtask

  initial begin
    int unsigned cyc;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    a_in      = '0;
    b_in      = '0;
    repeat (2) @(negedge clk);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_gcd_out", 32'(gcd_out), 32'd0);
    chk("rst_iter_out", 32'(iter_out), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    do_op(12, 18, 0, 0, 1'b0);
    do_op(255, 1, 0, 0, 1'b0);
    do_op(1, 255, 0, 0, 1'b0);
    do_op(0, 0, 0, 0, 1'b0);
    do_op(0, 35, 0, 0, 1'b0);
    do_op(35, 0, 0, 0, 1'b0);
    do_op(42, 42, 0, 0, 1'b0);
    do_op(60, 48, 0, 5, 1'b1);

    // Abort an operation partway through CALC
    out_ready = 1'b1;
    cyc = 0;
    while (!in_ready && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    in_valid = 1'b1;
    a_in     = 8'd200;
    b_in     = 8'd3;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (20) @(negedge clk);
    chk("mid_calc_busy", 32'(in_ready), 32'd0);
    #2 rst_n = 1'b0;
    #1;
    chk("abort_in_ready", 32'(in_ready), 32'd1);
    chk("abort_out_valid", 32'(out_valid), 32'd0);
    chk("abort_gcd_out", 32'(gcd_out), 32'd0);
    chk("abort_iter_out", 32'(iter_out), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    do_op(9, 6, 0, 0, 1'b0);

    for (int i = 0; i < 10; i++) begin
      do_op($urandom_range(0, 255), $urandom_range(0, 255),
            $urandom_range(0, 3), $urandom_range(0, 3), 1'b0);
    end

    chk("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/gcd_seq.md
Name: gcd_seq

Overview:
Parametrised, multi-cycle GCD engine using iterative subtraction. It performs one subtract step per clock, so WIDTH no longer drives a large combinational unrolled chain. Operands enter through a valid/ready handshake. Results leave through a second valid/ready handshake, together with the number of subtraction steps taken. The block serves as the reusable arithmetic core for any datapath needing GCD of unsigned operands up to WIDTH bits.

Parameters:
- WIDTH, 8, operand/result width in bits (unsigned); legal range 2..32.
- CNT_W, WIDTH, width of the iteration counter; must satisfy 2^CNT_W > 2^WIDTH - 2.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  operand pair valid.
- in_ready  output  1  block can accept operands.
- a_in  input  WIDTH  operand A.
- b_in  input  WIDTH  operand B.
- out_valid  output  1  result valid.
- out_ready  input  1  downstream accepts result.
- gcd_out  output  WIDTH  GCD result.
- iter_out  output  CNT_W  subtraction steps used.

Behaviour:
- Reset (async assert, sync release):
  - state=IDLE, internal a_r=b_r=0, iter=0.
  - in_ready=1, out_valid=0, gcd_out=0, iter_out=0.
- States are IDLE, CALC and DONE.
- IDLE:
  - in_ready=1.
  - On in_valid&&in_ready at a rising edge: a_r<=a_in, b_r<=b_in, iter<=0, go to CALC.
  - Operands are sampled only on that edge; later changes on a_in/b_in are ignored.
- CALC (in_ready=0, out_valid=0), evaluated each edge:
  - a_r==0: gcd_out<=b_r, go to DONE.
  - else b_r==0: gcd_out<=a_r, go to DONE.
  - else a_r==b_r: gcd_out<=a_r, go to DONE.
  - else a_r>b_r: a_r<=a_r-b_r, iter<=iter+1.
  - else: b_r<=b_r-a_r, iter<=iter+1.
  - On every transition to DONE: iter_out<=iter.
  - Subtraction never underflows, because the larger operand is always the minuend.
  - gcd(0,0)=0.
- Latency: out_valid rises k+1 cycles after the accept edge, where k = number of subtractions.
  - Zero or equal operands give k=0, so out_valid rises 1 cycle after accept.
- DONE:
  - out_valid=1; gcd_out and iter_out are held stable while out_ready=0.
  - On out_valid&&out_ready at an edge: out_valid<=0, go to IDLE.
  - in_ready rises in the following cycle; there is no same-cycle re-accept.
- gcd_out and iter_out keep their last values after the handshake until the next result is produced.
- Worst case: k = 2^WIDTH - 2 (e.g. operands 2^WIDTH-1 and 1). iter must not wrap.
- Reset asserted mid-CALC or mid-DONE aborts immediately; the in-flight result is discarded and all outputs return to reset values.
- Only one operation is in flight; no input buffering.

Test Plan:
- Basic result: reset, send a=12, b=18, out_ready=1.
  - Expect gcd_out=6, iter_out=2, out_valid high exactly 3 cycles after accept, in_ready low throughout.
- Worst case: WIDTH=8, a=255, b=1.
  - Expect gcd_out=1, iter_out=254, out_valid 255 cycles after accept.
  - Then a=1, b=255 gives the same result (symmetry).
- Zero and equal operands:
  - (0,0) -> 0; (0,35) -> 35; (35,0) -> 35; (42,42) -> 42.
  - Each with iter_out=0 and 1-cycle latency.
- Backpressure: a=60, b=48 with out_ready=0 for 5 cycles after out_valid.
  - Expect gcd_out=12 and iter_out=4 held stable, in_ready=0, and a new in_valid ignored.
  - Raise out_ready: out_valid drops next edge, in_ready returns one cycle later.
- Reset mid-operation: start a=200, b=3, pull rst_n low asynchronously mid-CALC.
  - Expect all outputs at reset values immediately.
  - After release, a=9, b=6 -> gcd_out=3, iter_out=2.
- Back-to-back: 10 random operand pairs with random in_valid/out_ready gaps.
  - Every gcd_out matches a reference model; no result is lost or duplicated.
